// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo block.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents: count_width() gives the occupancy counter width for a given
// pointer width (one extra bit so the counter can represent a full FIFO);
// default almost-empty level and the margin below depth for almost-full.
package sync_fifo_pkg;

    localparam int DEFAULT_ALMOST_EMPTY_LEVEL = 2;
    localparam int DEFAULT_ALMOST_FULL_MARGIN = 2;

    // Occupancy runs 0..2**address_width inclusive, so it needs one extra bit.
    function automatic int count_width(input int address_width);
        return address_width + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: simple dual-port RAM, one write and one read port.
// Latency: read data registered, valid the edge after rd_en.
// Backpressure: none; the controller only issues legal accesses.
//
// Ports:
//   Clk               rising-edge clock
//   Clear_in          synchronous active-high clear of the read register only
//   wr_en/wr_addr/wr_dat   write port
//   rd_en/rd_addr     read request
//   rd_dat            registered read data, held when rd_en is low
module sync_fifo_mem #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     Clk,
    input  logic                     Clear_in,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_dat,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_dat
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    // Array is deliberately left without a reset so it maps onto RAM macros.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Non-blocking read returns the pre-write word when rd_addr == wr_addr,
    // which gives read-before-write behaviour for a full FIFO pass-through.
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags and optional sticky error flags.
// Latency: Data_out registered, valid one edge after an accepted read.
// Backpressure: writes refused when full unless a read is accepted on the same edge; reads refused when empty.
//
// Ports:
//   Clk, Clear_in                      clock and synchronous active-high reset
//   Data_in, WriteEn_in                write side
//   ReadEn_in, Data_out                read side (Data_out holds between reads)
//   Count_out                          occupancy 0..FIFO_DEPTH
//   Full_out, Empty_out                occupancy flags
//   AlmostFull_out, AlmostEmpty_out    threshold flags
//   Overflow_out, Underflow_out        sticky error flags, present only when
//                                      SYNC_FIFO_ERR_FLAGS_EN is defined,
//                                      otherwise constant 0
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int FIFO_DEPTH         = 1 << ADDRESS_WIDTH,
    parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - DEFAULT_ALMOST_FULL_MARGIN,
    parameter int ALMOST_EMPTY_LEVEL = DEFAULT_ALMOST_EMPTY_LEVEL
) (
    input  logic                                 Clk,
    input  logic                                 Clear_in,
    input  logic [DATA_WIDTH-1:0]                Data_in,
    input  logic                                 WriteEn_in,
    output logic                                 Full_out,
    input  logic                                 ReadEn_in,
    output logic [DATA_WIDTH-1:0]                Data_out,
    output logic                                 Empty_out,
    output logic [count_width(ADDRESS_WIDTH)-1:0] Count_out,
    output logic                                 AlmostFull_out,
    output logic                                 AlmostEmpty_out,
    output logic                                 Overflow_out,
    output logic                                 Underflow_out
);

    localparam int CW = count_width(ADDRESS_WIDTH);

    localparam logic [CW-1:0]            DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]            AF_C      = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0]            AE_C      = CW'(ALMOST_EMPTY_LEVEL);
    localparam logic [CW-1:0]            CNT_ONE   = CW'(1);
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE   = ADDRESS_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_nxt;
    logic                     wr_acc;
    logic                     rd_acc;

    // A full FIFO can still take a write when a read frees a slot on the
    // same edge; an empty FIFO never services a read, even with a write.
    assign rd_acc = ReadEn_in & ~Empty_out;
    assign wr_acc = WriteEn_in & (~Full_out | ReadEn_in);

    always_comb begin
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CNT_ONE;
            2'b01:   count_nxt = count_q - CNT_ONE;
            default: count_nxt = count_q;
        endcase
    end

    // Flags are registered from count_nxt so they line up with Count_out.
    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count_q         <= '0;
            Full_out        <= 1'b0;
            Empty_out       <= 1'b1;
            AlmostFull_out  <= 1'b0;
            AlmostEmpty_out <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q         <= count_nxt;
            Full_out        <= (count_nxt == DEPTH_C);
            Empty_out       <= (count_nxt == '0);
            AlmostFull_out  <= (count_nxt >= AF_C);
            AlmostEmpty_out <= (count_nxt <= AE_C);
        end
    end

    assign Count_out = count_q;

    sync_fifo_mem #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_mem (
        .Clk      (Clk),
        .Clear_in (Clear_in),
        .wr_en    (wr_acc & ~Clear_in),
        .wr_addr  (wr_ptr),
        .wr_dat   (Data_in),
        .rd_en    (rd_acc),
        .rd_addr  (rd_ptr),
        .rd_dat   (Data_out)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    // Sticky until Clear_in; a write on a full FIFO is only an error when no
    // read makes room for it on the same edge.
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (WriteEn_in & Full_out & ~ReadEn_in) begin
                ovf_q <= 1'b1;
            end
            if (ReadEn_in & Empty_out) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign Overflow_out  = ovf_q;
    assign Underflow_out = unf_q;
`else
    assign Overflow_out  = 1'b0;
    assign Underflow_out = 1'b0;
`endif

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDRESS_WIDTH, default 4, pointer width; legal range 2..12.
REQ-003 Parameter FIFO_DEPTH, default 1 << ADDRESS_WIDTH, number of storage words; always equal to that default.
REQ-004 Parameter ALMOST_FULL_LEVEL, default FIFO_DEPTH-2, occupancy at or above which AlmostFull_out is asserted.
REQ-005 Parameter ALMOST_EMPTY_LEVEL, default 2, occupancy at or below which AlmostEmpty_out is asserted.
REQ-006 One clock; reset is synchronous and active-high. Ports are Clk and Clear_in.
REQ-007 Clk  input  1  single clock; all state changes on its rising edge.
REQ-008 Clear_in  input  1  synchronous active-high reset.
REQ-009 Data_in  input  DATA_WIDTH  write data.
REQ-010 WriteEn_in  input  1  write request.
REQ-011 Full_out  output  1  FIFO holds FIFO_DEPTH words.
REQ-012 ReadEn_in  input  1  read request.
REQ-013 Data_out  output  DATA_WIDTH  registered read data.
REQ-014 Empty_out  output  1  FIFO holds zero words.
REQ-015 Count_out  output  ADDRESS_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
REQ-016 AlmostFull_out, AlmostEmpty_out  output  1 each  threshold flags.
REQ-017 Overflow_out, Underflow_out  output  1 each  sticky error flags (see Configuration).

Function
REQ-018 A write SHALL be accepted when WriteEn_in & ~Full_out, or when WriteEn_in & ReadEn_in & Full_out. The accepted word is stored at the write pointer, and the write pointer increments modulo FIFO_DEPTH.
REQ-019 A read SHALL be accepted when ReadEn_in & ~Empty_out. Data_out takes the word at the read pointer on that same edge (latency 1), the read pointer increments modulo FIFO_DEPTH, and Data_out holds its value otherwise.
REQ-020 On a simultaneous read and write while full, both SHALL be accepted and Data_out SHALL return the old word (read-before-write); Count_out stays FIFO_DEPTH.
REQ-021 On a simultaneous read and write while empty, only the write SHALL be accepted, and Data_out is unchanged.
REQ-022 Count_out SHALL update as follows: +1 on a write-only accept, -1 on a read-only accept, unchanged on both or neither.
REQ-023 All flags SHALL be registered and derived from the next-state count, so they are valid in the same cycle as Count_out:
  - Full_out = (count == FIFO_DEPTH)
  - Empty_out = (count == 0)
  - AlmostFull_out = (count >= ALMOST_FULL_LEVEL)
  - AlmostEmpty_out = (count <= ALMOST_EMPTY_LEVEL)
REQ-024 Pointer wrap from FIFO_DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated words.
REQ-025 Rejected requests (write when full without a read, read when empty) SHALL leave all storage, pointers and the count unchanged.

Reset
REQ-026 When Clear_in = 1 at a rising Clk edge, the block SHALL reset as follows, overriding any concurrent request:
  - pointers and Count_out = 0
  - Empty_out = 1, AlmostEmpty_out = 1
  - Full_out = 0, AlmostFull_out = 0
  - Data_out = 0
  - Overflow_out = 0, Underflow_out = 0
REQ-027 Reset SHALL NOT clear storage contents; a reset mid-stream discards all queued words.

Configuration
REQ-028 With SYNC_FIFO_ERR_FLAGS_EN defined, Overflow_out SHALL set on WriteEn_in & Full_out & ~ReadEn_in, and Underflow_out SHALL set on ReadEn_in & Empty_out. Both remain set until Clear_in.
REQ-029 Without SYNC_FIFO_ERR_FLAGS_EN, Overflow_out and Underflow_out SHALL be tied to 0 and no error logic SHALL be synthesised.

Structure
REQ-030 Package sync_fifo_pkg SHALL hold the count-width helper function (ADDRESS_WIDTH+1) and the default threshold constants.
REQ-031 Storage SHALL be a sub-module sync_fifo_mem: a simple dual-port RAM with registered read port, of FIFO_DEPTH x DATA_WIDTH. Pointer and count control SHALL reside in sync_fifo.

Verification
REQ-032 Reset, then write 0x01..0x10 with DEPTH 16 -> Full_out = 1 after the 16th edge, AlmostFull_out = 1 from Count_out = 14, Empty_out = 0.
REQ-033 From full, read 16 times -> Data_out = 0x01..0x10 in order, one cycle after each accepted read; Empty_out = 1 after the last read.
REQ-034 Hold full with a continuous simultaneous read and write for 20 cycles -> Count_out stays 16, data order preserved across pointer wrap.
REQ-035 Empty FIFO with ReadEn_in = WriteEn_in = 1 (data 0xAA) -> Count_out = 1, Data_out unchanged; next read returns 0xAA.
REQ-036 With SYNC_FIFO_ERR_FLAGS_EN: write while full -> Overflow_out = 1 and sticky, contents intact; read while empty -> Underflow_out = 1. Without the macro, both flags stay 0.
REQ-037 Assert Clear_in at Count_out = 7 with both requests active -> next cycle Count_out = 0, Empty_out = 1, and all error flags = 0.
